brkpt_trigger: RTL

Hardware breakpoint controller for the 8051 debug path. It holds the programmed break address and drives the operand and enable inputs of the downstream 16-bit address equality comparator. It consumes the comparator's match result on each instruction-fetch strobe, skips a programmable number of passes, and raises a halt request to the core with a request/acknowledge handshake. It sits between the debug register interface and the CPU halt logic.

---
 rtl/brkpt_pkg.sv | 19 +
 rtl/brkpt_trigger.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/brkpt_pkg.sv
// Shared debug constants for the breakpoint trigger: FSM state codes,
// configuration register select codes and CTRL bit positions.
package brkpt_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_HALT_REQ = 2'd2;
   localparam logic [1:0] ST_HALTED   = 2'd3;

   localparam logic [1:0] SEL_BRK_ADDR = 2'd0;
   localparam logic [1:0] SEL_PASS     = 2'd1;
   localparam logic [1:0] SEL_CTRL     = 2'd2;
   localparam logic [1:0] SEL_RSVD     = 2'd3;

   localparam int CTRL_ARM        = 0;
   localparam int CTRL_AUTO_REARM = 1;
   localparam int CTRL_CLR_HIT    = 2;

endpackage

// File: rtl/brkpt_trigger.sv
// 8051 hardware breakpoint controller: drives the external address comparator,
// counts down skipped passes and runs the halt request/acknowledge handshake.
module brkpt_trigger
   import brkpt_pkg::*;
#(
   parameter int PASS_W = 8,
   parameter int HIT_W  = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              INSTR_STB,
   input  logic              MATCH,
   input  logic              CFG_WE,
   input  logic [1:0]        CFG_SEL,
   input  logic [15:0]       CFG_WDATA,
   input  logic              HALT_ACK,
   input  logic              RESUME,
   output logic [15:0]       BRK_ADDR,
   output logic              CMP_EN,
   output logic              HALT_REQ,
   output logic [HIT_W-1:0]  HIT_CNT,
   output logic [PASS_W-1:0] PASS_LEFT,
   output logic [1:0]        STATE
);

   logic [1:0]        state_q,       state_d;
   logic [15:0]       brk_addr_q,    brk_addr_d;
   logic [PASS_W-1:0] pass_reload_q, pass_reload_d;
   logic [PASS_W-1:0] pass_left_q,   pass_left_d;
   logic [HIT_W-1:0]  hit_cnt_q,     hit_cnt_d;
   logic              auto_rearm_q,  auto_rearm_d;
   logic              halt_req_q;
   logic              ctrl_wr;
   logic              hit_inc;

   assign ctrl_wr = CFG_WE && (CFG_SEL == SEL_CTRL);

   // Configuration registers, FSM next state and counters.
   always_comb begin
      state_d       = state_q;
      brk_addr_d    = brk_addr_q;
      pass_reload_d = pass_reload_q;
      pass_left_d   = pass_left_q;
      hit_cnt_d     = hit_cnt_q;
      auto_rearm_d  = auto_rearm_q;
      hit_inc       = 1'b0;

      if (CFG_WE && (CFG_SEL == SEL_BRK_ADDR)) begin
         brk_addr_d = CFG_WDATA;
      end else begin
         brk_addr_d = brk_addr_q;
      end

      if (CFG_WE && (CFG_SEL == SEL_PASS)) begin
         pass_reload_d = CFG_WDATA[PASS_W-1:0];
      end else begin
         pass_reload_d = pass_reload_q;
      end

      if (ctrl_wr) begin
         auto_rearm_d = CFG_WDATA[CTRL_AUTO_REARM];
      end else begin
         auto_rearm_d = auto_rearm_q;
      end

      // A CTRL write outranks everything else; a disarm wins over resume and ack.
      if (ctrl_wr && !CFG_WDATA[CTRL_ARM]) begin
         state_d = ST_IDLE;
      end else if (ctrl_wr && (state_q == ST_IDLE)) begin
         state_d     = ST_ARMED;
         pass_left_d = pass_reload_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ARMED: begin
               if (INSTR_STB && MATCH && !ctrl_wr) begin
                  if (pass_left_q == {PASS_W{1'b0}}) begin
                     state_d = ST_HALT_REQ;
                  end else begin
                     pass_left_d = pass_left_q - PASS_W'(1);
                  end
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_HALT_REQ: begin
               if (HALT_ACK) begin
                  state_d = ST_HALTED;
                  hit_inc = 1'b1;
               end else begin
                  state_d = ST_HALT_REQ;
               end
            end
            ST_HALTED: begin
               if (RESUME && auto_rearm_q) begin
                  state_d     = ST_ARMED;
                  pass_left_d = pass_reload_q;
               end else if (RESUME) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HALTED;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (ctrl_wr && CFG_WDATA[CTRL_CLR_HIT]) begin
         hit_cnt_d = {HIT_W{1'b0}};
      end else if (hit_inc && (hit_cnt_q != {HIT_W{1'b1}})) begin
         hit_cnt_d = hit_cnt_q + HIT_W'(1);
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
   end

   // State and register update; reset clears the halt request immediately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         brk_addr_q    <= 16'h0000;
         pass_reload_q <= {PASS_W{1'b0}};
         pass_left_q   <= {PASS_W{1'b0}};
         hit_cnt_q     <= {HIT_W{1'b0}};
         auto_rearm_q  <= 1'b0;
         halt_req_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         brk_addr_q    <= brk_addr_d;
         pass_reload_q <= pass_reload_d;
         pass_left_q   <= pass_left_d;
         hit_cnt_q     <= hit_cnt_d;
         auto_rearm_q  <= auto_rearm_d;
         halt_req_q    <= (state_d == ST_HALT_REQ);
      end
   end

   assign CMP_EN    = (state_q == ST_ARMED) && INSTR_STB;
   assign BRK_ADDR  = brk_addr_q;
   assign HALT_REQ  = halt_req_q;
   assign HIT_CNT   = hit_cnt_q;
   assign PASS_LEFT = pass_left_q;
   assign STATE     = state_q;

endmodule
